w_rom_fetch_ctrl: RTL



---
 rtl/w_rom_fetch_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/w_rom_fetch_ctrl.sv
// Weight-ROM read sequencer: one-time burn-in handshake, then a contiguous read run under consumer flow control.
// Optional burn-in timeout (sticky err) is enabled by defining WROM_FETCH_TIMEOUT_EN.
module w_rom_fetch_ctrl #(
    parameter int DATA_DEPTH   = 512,
    parameter int READ_LATENCY = 1,
    parameter int BURN_TIMEOUT = 4096,
    localparam int ADDR_WIDTH  = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic                  ready,
    input  logic                  burned,
    output logic                  burn_in_en,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  r_en,
    output logic                  valid_out,
    output logic                  last_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {S_IDLE, S_BURN, S_FETCH, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_WIDTH:0]     REM_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0]   ADDR_LAST = ADDR_WIDTH'(DATA_DEPTH - 1);
    // Stages still in flight after this cycle; the output stage itself is excluded.
    localparam logic [READ_LATENCY-1:0] PEND_MASK = READ_LATENCY'((1 << (READ_LATENCY - 1)) - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     rem_q, rem_d;
    logic                    seen_q, seen_d;
    logic                    burn_en_q;
    logic [READ_LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic [READ_LATENCY-1:0] last_sr_q, last_sr_d;
    logic                    last_issue;
    logic                    timeout;

`ifdef WROM_FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(BURN_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    assign timeout = (state_q == S_BURN) && !burned && (cnt_q == CNT_W'(BURN_TIMEOUT - 1));
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == S_BURN) ? cnt_q + 1'b1 : '0;
            if (timeout) err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    assign r_en       = (state_q == S_FETCH) && ready;
    assign last_issue = r_en && (rem_q == REM_ONE);
    assign vld_sr_d   = (vld_sr_q << 1) | READ_LATENCY'(r_en);
    assign last_sr_d  = (last_sr_q << 1) | READ_LATENCY'(last_issue);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        seen_d  = seen_q | burned;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d = base_addr;
                    rem_d  = num_words;
                    if (!(burned || seen_q))  state_d = S_BURN;
                    else if (num_words == '0) state_d = S_DONE;
                    else                      state_d = S_FETCH;
                end
            end
            S_BURN: begin
                if (burned)       state_d = (rem_q == '0) ? S_DONE : S_FETCH;
                else if (timeout) state_d = S_DONE;
            end
            S_FETCH: begin
                if (ready) begin
                    // Depth need not be a power of two, so wrap by explicit compare.
                    addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == REM_ONE) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((vld_sr_q & PEND_MASK) == '0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            seen_q    <= 1'b0;
            burn_en_q <= 1'b0;
            vld_sr_q  <= '0;
            last_sr_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            seen_q    <= seen_d;
            burn_en_q <= (state_d == S_BURN);
            vld_sr_q  <= vld_sr_d;
            last_sr_q <= last_sr_d;
        end
    end

    assign burn_in_en = burn_en_q;
    assign addr_out   = addr_q;
    assign valid_out  = vld_sr_q[READ_LATENCY-1];
    assign last_out   = last_sr_q[READ_LATENCY-1];
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule
